// File: rtl/mcycle_unit.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// Define MCYCLE_FAST_ZERO_EN to finish zero-operand / divide-by-zero ops at the Start edge.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, COMPUTING} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi, lo, dvsr, dvd;
    logic             is_div, neg_q, neg_r, dz;

    logic             start_ok, last, fast;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign start_ok = (state == IDLE) && Start;
    assign last     = (state == COMPUTING) && (count == CNT_LAST);
    assign a_neg    = MCycleOp[1] & Operand1[WIDTH-1];
    assign b_neg    = MCycleOp[1] & Operand2[WIDTH-1];
    assign a_mag    = a_neg ? -Operand1 : Operand1;
    assign b_mag    = b_neg ? -Operand2 : Operand2;

`ifdef MCYCLE_FAST_ZERO_EN
    assign fast = MCycleOp[0] ? (Operand2 == '0)
                              : ((Operand1 == '0) || (Operand2 == '0));
`else
    assign fast = 1'b0;
`endif

    // Multiply: hi:lo holds partial product with the multiplier shifting out of lo.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, dvsr} : '0);
    assign mul_hi = sum[WIDTH:1];
    assign mul_lo = {sum[0], lo[WIDTH-1:1]};

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    logic [WIDTH:0]   rsh, diff;
    logic             fits;
    logic [WIDTH-1:0] div_hi, div_lo;
    assign rsh    = {hi, lo[WIDTH-1]};
    assign diff   = rsh - {1'b0, dvsr};
    assign fits   = ~diff[WIDTH];
    assign div_hi = fits ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
    assign div_lo = {lo[WIDTH-2:0], fits};

    logic [WIDTH-1:0]   nxt_hi, nxt_lo, q_s, r_s, res1_fin, res2_fin;
    logic [2*WIDTH-1:0] prod, prod_s;
    assign nxt_hi = is_div ? div_hi : mul_hi;
    assign nxt_lo = is_div ? div_lo : mul_lo;
    assign prod   = {nxt_hi, nxt_lo};
    assign prod_s = neg_q ? -prod : prod;
    assign q_s    = neg_q ? -nxt_lo : nxt_lo;
    assign r_s    = neg_r ? -nxt_hi : nxt_hi;

    always_comb begin
        res1_fin = prod_s[WIDTH-1:0];
        res2_fin = prod_s[2*WIDTH-1:WIDTH];
        if (is_div) begin
            res1_fin = dz ? '1  : q_s;
            res2_fin = dz ? dvd : r_s;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        unique case (state)
            IDLE: begin
                Busy = Start;
                if (Start && !fast) state_nxt = COMPUTING;
            end
            COMPUTING: begin
                Busy = 1'b1;
                if (count == CNT_LAST) state_nxt = IDLE;
            end
        endcase
        if (RESET) Busy = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            dvsr    <= '0;
            dvd     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            Result1 <= '0;
            Result2 <= '0;
        end else if (start_ok) begin
            count  <= '0;
            hi     <= '0;
            lo     <= MCycleOp[0] ? a_mag : b_mag;
            dvsr   <= MCycleOp[0] ? b_mag : a_mag;
            dvd    <= Operand1;
            is_div <= MCycleOp[0];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= MCycleOp[0] && (Operand2 == '0);
            if (fast) begin
                Result1 <= MCycleOp[0] ? '1 : '0;
                Result2 <= MCycleOp[0] ? Operand1 : '0;
            end
        end else if (state == COMPUTING) begin
            hi <= nxt_hi;
            lo <= nxt_lo;
            if (last) begin
                count   <= '0;
                Result1 <= res1_fin;
                Result2 <= res2_fin;
            end else begin
                count <= count + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mcycle_unit.sv
// Bench for mcycle_unit: directed vector table, multi-cycle corner sequences,
// and random ops against an arithmetic reference model.
module tb_mcycle_unit;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1, Operand2;
    logic [W-1:0] Result1, Result2;
    logic         Busy;

    int ncmp = 0;
    int nbad = 0;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] r1, r2;
    } vec_t;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MCYCLE_FAST_ZERO_EN
        if (op[0] ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
        return W + 1;
    endfunction

    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r1, output logic [W-1:0] r2);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[0]) begin
            if (op[1]) p = 64'(sa * sb);
            else       p = {32'b0, a} * {32'b0, b};
            r1 = p[31:0];
            r2 = p[63:32];
        end else if (b == 0) begin
            r1 = '1;
            r2 = a;
        end else if (op[1]) begin
            q  = sa / sb;
            r  = sa % sb;
            r1 = 32'(q);
            r2 = 32'(r);
        end else begin
            r1 = a / b;
            r2 = a % b;
        end
    endfunction

    // Pulse Start for one cycle, scramble inputs afterwards, count Busy cycles.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e1, input logic [W-1:0] e2, input string nm);
        int cyc;
        @(negedge CLK);
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        cyc = 0;
        #1;
        while (Busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(posedge CLK);
            #1;
            Start = 1'b0;
            Operand1 = $urandom;
            Operand2 = $urandom;
            MCycleOp = 2'($urandom_range(3));
            @(negedge CLK);
        end
        chk({nm, " latency"}, W'(cyc), W'(exp_lat(op, a, b)));
        chk({nm, " Result1"}, Result1, e1);
        chk({nm, " Result2"}, Result2, e2);
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0] e1, e2, ra, rb;
        logic [1:0]   rop;
        logic         busy_all;

        RESET = 1'b1; Start = 1'b1; MCycleOp = 2'b00;
        Operand1 = 32'd3; Operand2 = 32'd4;
        #12;
        chk("reset Busy", W'(Busy), 0);
        chk("reset Result1", Result1, 0);
        chk("reset Result2", Result2, 0);
        Start = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;

        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
        vecs[1] = '{2'b10, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF};
        vecs[2] = '{2'b10, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000};
        vecs[3] = '{2'b01, 32'd100,      32'd7,        32'h0000000E, 32'h00000002};
        vecs[4] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[5] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        vecs[6] = '{2'b01, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'h00001234};
        vecs[7] = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[8] = '{2'b00, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000};
        vecs[9] = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r1, vecs[i].r2,
                  $sformatf("vec%0d", i));

        // Divide by zero, then results must hold while idle.
        do_op(2'b01, 32'h00001234, 32'h0, 32'hFFFFFFFF, 32'h00001234, "div0");
        repeat (10) begin
            @(negedge CLK);
            chk("div0 hold Result1", Result1, 32'hFFFFFFFF);
            chk("div0 hold Result2", Result2, 32'h00001234);
            chk("div0 hold Busy", W'(Busy), 0);
        end

        // Reset in the middle of an op, with an ignored restart at cycle 8.
        @(negedge CLK);
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd5; Operand2 = 32'd6;
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (8) @(negedge CLK);
        Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd77; Operand2 = 32'd3;
        #1 chk("restart ignored Busy", W'(Busy), 1);
        @(posedge CLK);
        #1 Start = 1'b0;
        repeat (4) @(negedge CLK);
        chk("pre-reset Busy", W'(Busy), 1);
        RESET = 1'b1;
        #1;
        chk("mid reset Busy", W'(Busy), 0);
        chk("mid reset Result1", Result1, 0);
        chk("mid reset Result2", Result2, 0);
        @(negedge CLK);
        RESET = 1'b0;
        do_op(2'b01, 32'd9, 32'd4, 32'd2, 32'd1, "post-reset div");

        // Start held high: back-to-back operations.
        busy_all = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd3; Operand2 = 32'd4;
            end
            if (i == 1) begin
                MCycleOp = 2'b01; Operand1 = 32'd10; Operand2 = 32'd3;
            end
            #1;
            if (Busy !== 1'b1) busy_all = 1'b0;
            if (i == W + 1) begin
                chk("b2b first Result1", Result1, 32'd12);
                chk("b2b first Result2", Result2, 32'd0);
            end
            if (i == 2 * (W + 1)) begin
                chk("b2b second Result1", Result1, 32'd3);
                chk("b2b second Result2", Result2, 32'd1);
            end
        end
        chk("b2b Busy continuous", W'(busy_all), 1);
        Start = 1'b0;
        for (int i = 0; i < 100 && Busy === 1'b1; i++) @(negedge CLK);
        chk("b2b drain Busy", W'(Busy), 0);
        chk("b2b last Result1", Result1, 32'd3);
        chk("b2b last Result2", Result2, 32'd1);

        // Randomized ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(3));
            case ($urandom_range(3))
                0:       ra = 32'h80000000;
                1:       ra = (n % 8 == 0) ? 32'h0 : 32'($urandom_range(1000));
                default: ra = $urandom;
            endcase
            case ($urandom_range(4))
                0:       rb = (n % 3 == 0) ? 32'h0 : 32'hFFFFFFFF;
                1:       rb = 32'($urandom_range(50));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, e1, e2);
            do_op(rop, ra, rb, e1, e2, $sformatf("rand%0d op%0d", n, rop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
